fetch_stage: RTL and testbench
==============================

// Module: fetch_stage
// PURPOSE
//  Instruction-fetch (IF) stage of the 5-stage pipeline inside pipeline_top; sits directly upstream of decode.
//  Owns the PC register, addresses the synchronous instruction memory and loads the IF/ID pipeline register.
//  Handles stall (load-use hazard), redirect (taken branch/jump from EX) and reset.
//  Memory is addressed with the NEXT PC, so imem_rdata is always aligned with the current pc_q (no skid buffer).
// PARAMETERS
//  PC_W      32            PC width in bits; PC arithmetic wraps modulo 2^PC_W
//  INSTR_W   32            instruction width
//  IMEM_AW   8             instruction-memory word-address width; imem_addr = pc_next[IMEM_AW+1:2]
//  RESET_PC  32'h0000_0000 PC value after reset
//  NOP_INSTR 32'h0000_0013 value loaded into ifid_instr on reset/bubble (addi x0,x0,0)
//  CNT_W     16            width of the fetch counter
// PORTS
//  CLK          in   1        clock, all state updates on rising edge
//  RST          in   1        synchronous, active-high reset
//  stall_i      in   1        hold PC and IF/ID (from hazard unit)
//  redirect_i   in   1        taken branch/jump resolved in EX
//  redirect_pc  in   PC_W     target PC for redirect_i
//  imem_addr    out  IMEM_AW  word address to sync instruction memory (combinational from pc_next)
//  imem_rdata   in   INSTR_W  instruction read last edge = instruction at pc_q
//  ifid_valid   out  1        IF/ID holds a real instruction
//  ifid_pc      out  PC_W     PC of instruction in IF/ID
//  ifid_pc4     out  PC_W     ifid_pc + 4 (wrapping)
//  ifid_instr   out  INSTR_W  instruction in IF/ID
//  misalign_o   out  1        sticky: a redirect target had pc[1:0] != 0
//  fetch_cnt    out  CNT_W    count of instructions accepted into IF/ID
// BEHAVIOUR
//  Registers: pc_q, f_valid (pc_q/imem_rdata pair is meaningful), IF/ID set, misalign, fetch_cnt.
//  pc_next (comb): RST ? RESET_PC : redirect_i ? {redirect_pc[PC_W-1:2],2'b00} : stall_i ? pc_q : pc_q+4.
//  imem_addr = pc_next[IMEM_AW+1:2] every cycle, incl. during RST; upper PC bits ignored (aliasing).
//  Edge with RST=1: pc_q<=RESET_PC, f_valid<=1, ifid_valid<=0, ifid_pc<=0, ifid_pc4<=4,
//   ifid_instr<=NOP_INSTR, misalign_o<=0, fetch_cnt<=0. Reset mid-operation discards everything in flight.
//  Priority per edge: RST > redirect_i > stall_i > normal.
//  Normal (no stall/redirect): IF/ID <= {f_valid, pc_q, pc_q+4, imem_rdata}; pc_q <= pc_q+4; f_valid<=1;
//   fetch_cnt += 1 if f_valid.
//  Stall: pc_q, IF/ID, fetch_cnt held; imem_addr re-presents pc_q so imem_rdata stays valid next cycle.
//  Redirect (with or without stall): IF/ID <= bubble (valid=0, instr=NOP_INSTR, pc/pc4 held);
//   pc_q <= aligned target; f_valid<=1; fetch_cnt unchanged. Target fetched in 1 cycle, in IF/ID 2nd edge.
//  Redirect penalty: exactly one bubble in IF/ID (the wrong-path instr at pc_q is dropped).
//  misalign_o set on redirect edge when redirect_pc[1:0]!=0; only RST clears it; PC low bits forced 0.
//  Latency: instr at PC p appears in IF/ID one edge after pc_q==p with stall_i=0.
//  PC wrap: pc_q = 2^PC_W-4 -> next pc_q = 0, ifid_pc4 = 0. fetch_cnt wraps at 2^CNT_W.
//  All outputs registered except imem_addr. No X on outputs after the first reset edge.
// TESTING
//  Memory word k = 32'h1000_0000+k. Reset 2 cycles, release -> first edge: ifid_pc=0,instr=0x10000000,valid=1;
//   ifid_pc then 4,8,12 on successive edges; fetch_cnt=3 after third.
//  Stall 3 cycles while ifid_pc=8 -> IF/ID holds pc 8/instr 0x10000002, imem_addr=3, fetch_cnt frozen;
//   release -> next edge ifid_pc=12.
//  redirect_i=1, redirect_pc=0x40 when pc_q=0x10 -> next edge ifid_valid=0, instr=0x00000013;
//   following edge ifid_pc=0x40, instr=0x10000010.
//  Redirect with stall_i=1 same cycle -> redirect wins (same result as above); redirect_pc=0x42 -> pc 0x40, misalign_o=1 until RST.
//  PC_W=8 build, run from 0xF8 -> ifid_pc 0xF8,0xFC,0x00; ifid_pc4 at 0xFC = 0x00.
//  Assert RST for 1 cycle mid-stream (after redirect) -> next edge all outputs at reset values, fetch resumes at RESET_PC.

Source files
------------

// File: rtl/fetch_stage_if.sv
// Bundles the IF stage's control inputs, instruction-memory port and IF/ID outputs.
// The slave modport is the fetch stage; the master side drives the controls and the memory.
interface fetch_stage_if #(
   parameter int PC_W    = 32,
   parameter int INSTR_W = 32,
   parameter int IMEM_AW = 8,
   parameter int CNT_W   = 16
);
   logic               stall_i;
   logic               redirect_i;
   logic [PC_W-1:0]    redirect_pc;
   logic [IMEM_AW-1:0] imem_addr;
   logic [INSTR_W-1:0] imem_rdata;
   logic               ifid_valid;
   logic [PC_W-1:0]    ifid_pc;
   logic [PC_W-1:0]    ifid_pc4;
   logic [INSTR_W-1:0] ifid_instr;
   logic               misalign_o;
   logic [CNT_W-1:0]   fetch_cnt;

   modport slave (
      input  stall_i, redirect_i, redirect_pc, imem_rdata,
      output imem_addr, ifid_valid, ifid_pc, ifid_pc4, ifid_instr, misalign_o, fetch_cnt
   );

   modport master (
      output stall_i, redirect_i, redirect_pc, imem_rdata,
      input  imem_addr, ifid_valid, ifid_pc, ifid_pc4, ifid_instr, misalign_o, fetch_cnt
   );
endinterface

// File: rtl/fetch_stage.sv
// Instruction-fetch stage: owns the PC, addresses the synchronous imem with the next PC
// so imem_rdata always matches pc_q, and loads the IF/ID register.
module fetch_stage #(
   parameter int                   PC_W      = 32,
   parameter int                   INSTR_W   = 32,
   parameter int                   IMEM_AW   = 8,
   parameter logic [PC_W-1:0]      RESET_PC  = '0,
   parameter logic [INSTR_W-1:0]   NOP_INSTR = INSTR_W'(32'h0000_0013),
   parameter int                   CNT_W     = 16
) (
   input  logic         CLK,
   input  logic         RST,
   fetch_stage_if.slave bus
);

   localparam logic [PC_W-1:0]  PC_STEP = PC_W'(4);
   localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

   logic [PC_W-1:0]    pc_q, pc_d;
   logic               f_valid_q, f_valid_d;
   logic               ifid_valid_q, ifid_valid_d;
   logic [PC_W-1:0]    ifid_pc_q, ifid_pc_d;
   logic [PC_W-1:0]    ifid_pc4_q, ifid_pc4_d;
   logic [INSTR_W-1:0] ifid_instr_q, ifid_instr_d;
   logic               misalign_q, misalign_d;
   logic [CNT_W-1:0]   fetch_cnt_q, fetch_cnt_d;
   logic [PC_W-1:0]    pc_plus4;

   assign pc_plus4 = pc_q + PC_STEP;

   always_comb begin
      pc_d         = pc_q;
      f_valid_d    = f_valid_q;
      ifid_valid_d = ifid_valid_q;
      ifid_pc_d    = ifid_pc_q;
      ifid_pc4_d   = ifid_pc4_q;
      ifid_instr_d = ifid_instr_q;
      misalign_d   = misalign_q;
      fetch_cnt_d  = fetch_cnt_q;

      if (RST) begin
         pc_d         = RESET_PC;
         f_valid_d    = 1'b1;
         ifid_valid_d = 1'b0;
         ifid_pc_d    = '0;
         ifid_pc4_d   = PC_STEP;
         ifid_instr_d = NOP_INSTR;
         misalign_d   = 1'b0;
         fetch_cnt_d  = '0;
      end else if (bus.redirect_i) begin
         // The wrong-path instruction sitting at pc_q is dropped; IF/ID becomes a bubble.
         pc_d         = {bus.redirect_pc[PC_W-1:2], 2'b00};
         f_valid_d    = 1'b1;
         ifid_valid_d = 1'b0;
         ifid_instr_d = NOP_INSTR;
         if (bus.redirect_pc[1:0] != 2'b00) begin
            misalign_d = 1'b1;
         end
      end else if (!bus.stall_i) begin
         pc_d         = pc_plus4;
         f_valid_d    = 1'b1;
         ifid_valid_d = f_valid_q;
         ifid_pc_d    = pc_q;
         ifid_pc4_d   = pc_plus4;
         ifid_instr_d = bus.imem_rdata;
         if (f_valid_q) begin
            fetch_cnt_d = fetch_cnt_q + CNT_ONE;
         end
      end

      // On stall pc_d == pc_q, so the memory re-reads the held instruction.
      bus.imem_addr = pc_d[IMEM_AW+1:2];
   end

   always_ff @(posedge CLK) begin
      if (RST) begin
         pc_q         <= RESET_PC;
         f_valid_q    <= 1'b1;
         ifid_valid_q <= 1'b0;
         ifid_pc_q    <= '0;
         ifid_pc4_q   <= PC_STEP;
         ifid_instr_q <= NOP_INSTR;
         misalign_q   <= 1'b0;
         fetch_cnt_q  <= '0;
      end else begin
         pc_q         <= pc_d;
         f_valid_q    <= f_valid_d;
         ifid_valid_q <= ifid_valid_d;
         ifid_pc_q    <= ifid_pc_d;
         ifid_pc4_q   <= ifid_pc4_d;
         ifid_instr_q <= ifid_instr_d;
         misalign_q   <= misalign_d;
         fetch_cnt_q  <= fetch_cnt_d;
      end
   end

   assign bus.ifid_valid = ifid_valid_q;
   assign bus.ifid_pc    = ifid_pc_q;
   assign bus.ifid_pc4   = ifid_pc4_q;
   assign bus.ifid_instr = ifid_instr_q;
   assign bus.misalign_o = misalign_q;
   assign bus.fetch_cnt  = fetch_cnt_q;

endmodule

// File: tb/tb_fetch_stage.sv
// Bench for fetch_stage: directed scenarios plus randomized stall/redirect/reset traffic
// compared against an instruction-stream model; a second 8-bit-PC build covers PC wrap.
module tb_fetch_stage;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   fetch_stage_if #(.PC_W(32), .INSTR_W(32), .IMEM_AW(8), .CNT_W(16)) ia ();
   fetch_stage_if #(.PC_W(8),  .INSTR_W(32), .IMEM_AW(6), .CNT_W(16)) ib ();

   fetch_stage #(.PC_W(32), .INSTR_W(32), .IMEM_AW(8), .RESET_PC(32'h0), .CNT_W(16))
      dut_a (.CLK(clk), .RST(rst), .bus(ia.slave));
   fetch_stage #(.PC_W(8), .INSTR_W(32), .IMEM_AW(6), .RESET_PC(8'hF8), .CNT_W(16))
      dut_b (.CLK(clk), .RST(rst), .bus(ib.slave));

   // Synchronous instruction memories: word k holds 0x1000_0000 + k.
   always @(posedge clk) begin
      ia.imem_rdata <= 32'h1000_0000 + 32'(ia.imem_addr);
      ib.imem_rdata <= 32'h1000_0000 + 32'(ib.imem_addr);
   end

   int n_pass  = 0;
   int n_total = 0;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_total++;
      assert (obs === exp) n_pass++;
      else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
   endtask

   // Reference: what the IF/ID register should hold, from the stream rules.
   logic [31:0] m_pc, m_ipc, m_ipc4, m_instr;
   logic        m_fv, m_v, m_mis;
   logic [15:0] m_cnt;

   function automatic logic [31:0] mem_word(input logic [31:0] pc);
      return 32'h1000_0000 + ((pc / 4) % 256);
   endfunction

   task automatic tick();
      logic        r, s, d;
      logic [31:0] t, npc;
      #1;
      r = rst; s = ia.stall_i; d = ia.redirect_i; t = ia.redirect_pc;
      if (r)      npc = 32'h0;
      else if (d) npc = t - (t % 4);
      else if (s) npc = m_pc;
      else        npc = m_pc + 32'd4;
      chk("A.imem_addr", 64'(ia.imem_addr), 64'((npc / 4) % 256));
      @(posedge clk);
      if (r) begin
         m_pc = 0; m_fv = 1; m_v = 0; m_ipc = 0; m_ipc4 = 4;
         m_instr = 32'h13; m_mis = 0; m_cnt = 0;
      end else if (d) begin
         m_v = 0; m_instr = 32'h13; m_pc = npc; m_fv = 1;
         if (t % 4 != 0) m_mis = 1;
      end else if (!s) begin
         m_v = m_fv; m_ipc = m_pc; m_ipc4 = m_pc + 32'd4; m_instr = mem_word(m_pc);
         if (m_fv) m_cnt = m_cnt + 16'd1;
         m_pc = m_pc + 32'd4; m_fv = 1;
      end
      @(negedge clk);
      chk("A.ifid_valid", 64'(ia.ifid_valid), 64'(m_v));
      chk("A.ifid_pc",    64'(ia.ifid_pc),    64'(m_ipc));
      chk("A.ifid_pc4",   64'(ia.ifid_pc4),   64'(m_ipc4));
      chk("A.ifid_instr", 64'(ia.ifid_instr), 64'(m_instr));
      chk("A.misalign",   64'(ia.misalign_o), 64'(m_mis));
      chk("A.fetch_cnt",  64'(ia.fetch_cnt),  64'(m_cnt));
   endtask

   initial begin
      ia.stall_i = 0; ia.redirect_i = 0; ia.redirect_pc = 0;
      ib.stall_i = 0; ib.redirect_i = 0; ib.redirect_pc = 0;
      rst = 1;
      tick(); tick();
      chk("rst.valid", 64'(ia.ifid_valid), 64'h0);
      chk("rst.pc",    64'(ia.ifid_pc),    64'h0);
      chk("rst.pc4",   64'(ia.ifid_pc4),   64'h4);
      chk("rst.instr", 64'(ia.ifid_instr), 64'h13);
      chk("rst.cnt",   64'(ia.fetch_cnt),  64'h0);
      chk("rst.mis",   64'(ia.misalign_o), 64'h0);

      rst = 0;
      tick();
      chk("first.pc",    64'(ia.ifid_pc),    64'h0);
      chk("first.instr", 64'(ia.ifid_instr), 64'h1000_0000);
      chk("first.valid", 64'(ia.ifid_valid), 64'h1);
      chk("B.pc0",       64'(ib.ifid_pc),    64'hF8);
      chk("B.instr0",    64'(ib.ifid_instr), 64'h1000_003E);
      tick();
      chk("seq.pc4",     64'(ia.ifid_pc),    64'h4);
      chk("B.pc1",       64'(ib.ifid_pc),    64'hFC);
      chk("B.pc4_wrap",  64'(ib.ifid_pc4),   64'h00);
      chk("B.instr1",    64'(ib.ifid_instr), 64'h1000_003F);
      tick();
      chk("seq.pc8",     64'(ia.ifid_pc),    64'h8);
      chk("seq.cnt3",    64'(ia.fetch_cnt),  64'd3);
      chk("B.pc2",       64'(ib.ifid_pc),    64'h00);
      chk("B.instr2",    64'(ib.ifid_instr), 64'h1000_0000);

      ia.stall_i = 1;
      for (int i = 0; i < 3; i++) begin
         tick();
         chk("stall.pc",    64'(ia.ifid_pc),    64'h8);
         chk("stall.instr", 64'(ia.ifid_instr), 64'h1000_0002);
         chk("stall.addr",  64'(ia.imem_addr),  64'h3);
         chk("stall.cnt",   64'(ia.fetch_cnt),  64'd3);
      end
      ia.stall_i = 0;
      tick();
      chk("unstall.pc", 64'(ia.ifid_pc), 64'hC);

      ia.redirect_i = 1; ia.redirect_pc = 32'h40;
      tick();
      chk("redir.valid", 64'(ia.ifid_valid), 64'h0);
      chk("redir.instr", 64'(ia.ifid_instr), 64'h13);
      ia.redirect_i = 0;
      tick();
      chk("redir.pc",     64'(ia.ifid_pc),    64'h40);
      chk("redir.tinstr", 64'(ia.ifid_instr), 64'h1000_0010);

      ia.redirect_i = 1; ia.stall_i = 1; ia.redirect_pc = 32'h42;
      tick();
      chk("rs.valid", 64'(ia.ifid_valid), 64'h0);
      chk("rs.mis",   64'(ia.misalign_o), 64'h1);
      ia.redirect_i = 0; ia.stall_i = 0;
      tick();
      chk("rs.pc",    64'(ia.ifid_pc),    64'h40);
      chk("rs.instr", 64'(ia.ifid_instr), 64'h1000_0010);

      ia.redirect_i = 1; ia.redirect_pc = 32'hFFFF_FFFC;
      tick();
      ia.redirect_i = 0;
      tick();
      chk("wrap.pc",    64'(ia.ifid_pc),    64'hFFFF_FFFC);
      chk("wrap.pc4",   64'(ia.ifid_pc4),   64'h0);
      chk("wrap.instr", 64'(ia.ifid_instr), 64'h1000_00FF);
      tick();
      chk("wrap.next",  64'(ia.ifid_pc),    64'h0);
      chk("mis.sticky", 64'(ia.misalign_o), 64'h1);

      rst = 1;
      tick();
      chk("mrst.valid", 64'(ia.ifid_valid), 64'h0);
      chk("mrst.instr", 64'(ia.ifid_instr), 64'h13);
      chk("mrst.mis",   64'(ia.misalign_o), 64'h0);
      chk("mrst.cnt",   64'(ia.fetch_cnt),  64'h0);
      rst = 0;
      tick();
      chk("resume.pc",  64'(ia.ifid_pc),    64'h0);
      chk("resume.cnt", 64'(ia.fetch_cnt),  64'd1);

      for (int i = 0; i < 400; i++) begin
         rst            = ($urandom_range(0, 99) < 2);
         ia.stall_i     = ($urandom_range(0, 99) < 30);
         ia.redirect_i  = ($urandom_range(0, 99) < 12);
         ia.redirect_pc = $urandom;
         tick();
      end

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
